uart_receiver: RTL and testbench

- UART serial-to-parallel receiver; the receive end of the team's 8N1 UART link.
- Pairs with the existing UART transmitter at the same CLKS_PER_BIT, so the two can run in loopback.
- Synchronises the asynchronous line, detects and validates the start bit, samples data LSB-first at mid-bit, checks the stop bit, then presents the byte with a one-cycle valid strobe.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_receiver_if.sv | 40 ++++
 rtl/uart_sync.sv | 35 +++
 rtl/uart_receiver.sv | 213 +++++++++++++++++++++
 tb/tb_uart_receiver.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width, default bit period.
// Latency: none (package of constants and a combinational helper).
// Backpressure: none.
package uart_pkg;

    // Data bits per frame; the link is 8N1 (optionally 8E1/8O1).
    localparam int DATA_BITS = 8;

    // Default clocks per bit period, shared with the transmitter so a
    // loopback pair agrees on the baud rate without extra plumbing.
    localparam int CLKS_PER_BIT_DFLT = 87;

    // Receiver FSM states. PARITY is only reachable in parity builds.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } uart_state_t;

    // Expected parity bit for a data byte: even parity is the XOR of the
    // data bits; odd parity is its inverse.
    function automatic logic frame_parity(input logic [DATA_BITS-1:0] data,
                                          input logic                 odd);
        return (^data) ^ odd;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle: serial line in, received byte and status strobes out.
// Latency: none (wiring only).
// Backpressure: none; the strobes are one-cycle pulses the consumer must catch.
interface uart_receiver_if;
    import uart_pkg::*;

    logic                 i_Serial_Data;
    logic [DATA_BITS-1:0] o_Byte;
    logic                 o_DV;
    logic                 o_Frame_Err;
    logic                 o_Sig_Active;
`ifdef UART_RX_PARITY_EN
    logic                 o_Parity_Err;
`endif

    // Receiver side: consumes the line, produces byte and status.
    modport master (
        input  i_Serial_Data,
        output o_Byte,
        output o_DV,
        output o_Frame_Err,
`ifdef UART_RX_PARITY_EN
        output o_Parity_Err,
`endif
        output o_Sig_Active
    );

    // Consumer side: drives the line, observes byte and status.
    modport slave (
        output i_Serial_Data,
        input  o_Byte,
        input  o_DV,
        input  o_Frame_Err,
`ifdef UART_RX_PARITY_EN
        input  o_Parity_Err,
`endif
        input  o_Sig_Active
    );

endinterface : uart_receiver_if

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, plus one extra previous-sample flop for edge detection.
// Latency: 2 clk to sync_o, 3 clk to prev_o.
// Backpressure: none.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic prev_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Shift the async input through the metastability chain; all flops reset
    // to RESET_VAL so an idle-high line shows no edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign prev_o = prev_q;

endmodule : uart_sync

// File: rtl/uart_receiver.sv
// UART 8N1 serial-to-parallel receiver; optional parity bit when UART_RX_PARITY_EN is defined.
// Latency: o_DV about 9.5*CLKS_PER_BIT + (0..4) clk after the start-bit falling edge.
// Backpressure: none; o_DV / o_Frame_Err / o_Parity_Err are single-cycle pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_receiver_if.master rx_if
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    // Half-bit point used to validate the start bit; full-bit point used to
    // step from one mid-bit sample to the next.
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    logic r_Rx;
    logic r_Rx_q;
    logic start_edge;

    uart_state_t          state_q,  state_d;
    logic [CW-1:0]        cnt_q,    cnt_d;
    logic [IW-1:0]        idx_q,    idx_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [DATA_BITS-1:0] byte_q,   byte_d;
    logic                 dv_q,     dv_d;
    logic                 ferr_q,   ferr_d;
    logic                 active_q, active_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q,    par_d;
    logic                 perr_q,   perr_d;
`endif

    uart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (rx_if.i_Serial_Data),
        .sync_o  (r_Rx),
        .prev_o  (r_Rx_q)
    );

    // Only a high-to-low transition starts a frame, so a line held low
    // (break, or a stuck stop bit) cannot retrigger the receiver.
    assign start_edge = r_Rx_q & ~r_Rx;

    // State and datapath registers; reset aborts any partial frame silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            ferr_q   <= ferr_d;
            active_q <= active_d;
`ifdef UART_RX_PARITY_EN
            par_q    <= par_d;
            perr_q   <= perr_d;
`endif
        end
    end

    // Next-state and output decode: sample the line mid-bit, assemble the
    // byte LSB first, and classify the frame at the stop-bit sample.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        ferr_d   = 1'b0;
        active_d = active_q;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
        perr_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (start_edge) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end

            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!r_Rx) begin
                        state_d = DATA;
                    end else begin
                        // Line went back high before mid-bit: treat as a
                        // glitch and drop it without reporting anything.
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = r_Rx;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    par_d   = r_Rx;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = CLEANUP;
                    if (r_Rx) begin
`ifdef UART_RX_PARITY_EN
                        // Framing is checked first; a good stop bit with a
                        // bad parity bit reports parity instead of data.
                        if (par_q != frame_parity(shift_q, PARITY_ODD != 0)) begin
                            perr_d = 1'b1;
                        end else begin
                            byte_d = shift_q;
                            dv_d   = 1'b1;
                        end
`else
                        byte_d = shift_q;
                        dv_d   = 1'b1;
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            CLEANUP: begin
                // Return to IDLE at mid stop bit; the rest of the stop bit
                // elapses in IDLE so a back-to-back start edge is caught.
                cnt_d    = '0;
                active_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign rx_if.o_Byte       = byte_q;
    assign rx_if.o_DV         = dv_q;
    assign rx_if.o_Frame_Err  = ferr_q;
    assign rx_if.o_Sig_Active = active_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.o_Parity_Err = perr_q;
`endif

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// Randomised bench for uart_receiver: a bit-level line driver, a frame-level reference model and an output event monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_receiver;

    localparam int CPB = 87;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam int EV_DV   = 1;
    localparam int EV_FERR = 2;
    localparam int EV_PERR = 3;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_mis;
    int   both_seen;
    int   last_good;
    int   fall_cyc;

    ev_t  evq[$];
    ev_t  expq[$];

    uart_receiver_if u_if ();

    uart_receiver #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output strobe with the byte visible at that moment.
    always @(negedge clk) begin
        if (u_if.o_DV) evq.push_back('{kind: EV_DV, data: int'(u_if.o_Byte), cyc: cyc});
        if (u_if.o_Frame_Err) evq.push_back('{kind: EV_FERR, data: int'(u_if.o_Byte), cyc: cyc});
`ifdef UART_RX_PARITY_EN
        if (u_if.o_Parity_Err) evq.push_back('{kind: EV_PERR, data: int'(u_if.o_Byte), cyc: cyc});
        if (u_if.o_Parity_Err && (u_if.o_DV || u_if.o_Frame_Err)) both_seen = 1;
`endif
        if (u_if.o_DV && u_if.o_Frame_Err) both_seen = 1;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        u_if.i_Serial_Data = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        u_if.i_Serial_Data = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Line driver: start, 8 data bits LSB first, optional even parity
    // (inverted when par_flip), then the chosen stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_b);
    endtask

    // Reference model: what a receiver must report for one whole frame.
    task automatic model_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        if (!stop_b) begin
            expq.push_back('{kind: EV_FERR, data: last_good, cyc: 0});
`ifdef UART_RX_PARITY_EN
        end else if (par_flip) begin
            expq.push_back('{kind: EV_PERR, data: last_good, cyc: 0});
`endif
        end else begin
            last_good = int'(d);
            expq.push_back('{kind: EV_DV, data: last_good, cyc: 0});
        end
    endtask

    task automatic tx(input logic [7:0] d, input logic stop_b, input logic par_flip);
        model_frame(d, stop_b, par_flip);
        send_frame(d, stop_b, par_flip);
    endtask

    task automatic compare_events(input string tag);
        int n;
        chk({tag, "_count"}, evq.size(), expq.size());
        n = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_kind%0d", tag, i), evq[i].kind, expq[i].kind);
            chk($sformatf("%s_byte%0d", tag, i), evq[i].data, expq[i].data);
        end
        evq.delete();
        expq.delete();
    endtask

    initial begin
        int f0;
        int gap;
        logic prev_bad;
        logic [7:0] d;
        logic sb;
        logic pf;

        cyc       = 0;
        n_cmp     = 0;
        n_mis     = 0;
        both_seen = 0;
        last_good = 0;
        fall_cyc  = 0;
        rst_n     = 1'b0;
        u_if.i_Serial_Data = 1'b1;

        // Reset values
        repeat (5) @(negedge clk);
        chk("rst_byte", int'(u_if.o_Byte), 0);
        chk("rst_dv", int'(u_if.o_DV), 0);
        chk("rst_ferr", int'(u_if.o_Frame_Err), 0);
        chk("rst_active", int'(u_if.o_Sig_Active), 0);
`ifdef UART_RX_PARITY_EN
        chk("rst_perr", int'(u_if.o_Parity_Err), 0);
`endif
        rst_n = 1'b1;
        idle(20);
        chk("idle_no_event", evq.size(), 0);

        // Single frame 0x3F, with latency from the start-bit edge
        tx(8'h3F, 1'b1, 1'b0);
        f0 = fall_cyc;
        idle(2 * CPB);
        if (evq.size() > 0) begin
            chk("lat_window", int'((evq[0].cyc - f0) >= 9 * CPB + CPB / 2 - 1 &&
                                   (evq[0].cyc - f0) <= 9 * CPB + CPB / 2 + 5), 1);
        end
        chk("3f_active_low", int'(u_if.o_Sig_Active), 0);
        chk("3f_byte_held", int'(u_if.o_Byte), 8'h3F);
        compare_events("f3f");

        // Back-to-back 0xA5, 0x5A with no idle gap
        tx(8'hA5, 1'b1, 1'b0);
        tx(8'h5A, 1'b1, 1'b0);
        idle(2 * CPB);
        if (evq.size() == 2) begin
            gap = evq[1].cyc - evq[0].cyc - FRAME_BITS * CPB;
            chk("b2b_spacing", int'(gap >= -2 && gap <= 2), 1);
        end
        compare_events("b2b");

        // Short low glitch: active briefly, then dropped without report
        u_if.i_Serial_Data = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_active", int'(u_if.o_Sig_Active), 1);
        repeat (10) @(negedge clk);
        u_if.i_Serial_Data = 1'b1;
        repeat (50) @(negedge clk);
        chk("glitch_active_drop", int'(u_if.o_Sig_Active), 0);
        idle(2 * CPB);
        compare_events("glitch");

        // Bad stop bit followed by a 2000-cycle break
        tx(8'h81, 1'b0, 1'b0);
        repeat (2000) @(negedge clk);
        chk("break_byte_held", int'(u_if.o_Byte), last_good);
        chk("break_active", int'(u_if.o_Sig_Active), 0);
        idle(3 * CPB);
        compare_events("break");

        // Reset in the middle of data bit 4 of 0xFF, then 0x12
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        u_if.i_Serial_Data = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        chk("mid_active", int'(u_if.o_Sig_Active), 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_byte", int'(u_if.o_Byte), 0);
        chk("mid_rst_active", int'(u_if.o_Sig_Active), 0);
        chk("mid_rst_dv", int'(u_if.o_DV), 0);
        rst_n     = 1'b1;
        last_good = 0;
        idle(10 * CPB);
        tx(8'h12, 1'b1, 1'b0);
        idle(2 * CPB);
        chk("after_rst_byte", int'(u_if.o_Byte), 8'h12);
        compare_events("midrst");

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1; send 0 then 1
        tx(8'h07, 1'b1, 1'b1);
        idle(2 * CPB);
        tx(8'h07, 1'b1, 1'b0);
        idle(2 * CPB);
        chk("par_byte", int'(u_if.o_Byte), 8'h07);
        compare_events("parity");
`endif

        // Randomised frames: random data, gaps, stop errors (and parity errors)
        prev_bad = 1'b0;
        for (int n = 0; n < 30; n++) begin
            d   = 8'($urandom_range(0, 255));
            sb  = ($urandom_range(0, 7) != 0);
            pf  = 1'b0;
`ifdef UART_RX_PARITY_EN
            pf  = ($urandom_range(0, 7) == 0);
`endif
            gap = $urandom_range(0, 3) * CPB + $urandom_range(0, 7);
            if (prev_bad && gap < CPB) gap = CPB;
            if (gap > 0) idle(gap);
            tx(d, sb, pf);
            prev_bad = ~sb;
        end
        idle(2 * CPB);
        chk("rand_byte_held", int'(u_if.o_Byte), last_good);
        compare_events("rand");

        chk("strobes_exclusive", both_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_uart_receiver
